// File: rtl/pn_pkg.sv
// Shared definitions for the spike receiver: packet classes, field positions,
// split-FSM state encoding and the syn-index decode helpers.
package pn_pkg;

  localparam int ADDR_W    = 16;
  localparam int DATA_W    = 32;
  localparam int PKT_W     = ADDR_W + DATA_W;
  localparam int IDX_W     = 7;
  localparam int CLASS_BIT = 15;
  localparam int RICH_BIT  = 12;
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    PKT_PARAM = 2'd0,
    PKT_DUAL  = 2'd1,
    PKT_RICH  = 2'd2
  } pkt_class_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FIRST  = 2'd1,
    ST_SECOND = 2'd2
  } split_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } pkt_t;

  function automatic pkt_class_e pkt_class(input logic [ADDR_W-1:0] addr);
    pkt_class_e cls;
    if (addr[CLASS_BIT]) cls = PKT_PARAM;
    else if (addr[RICH_BIT]) cls = PKT_RICH;
    else cls = PKT_DUAL;
    return cls;
  endfunction

  function automatic logic [IDX_W-1:0] dual_idx0(input logic [ADDR_W-1:0] addr);
    return {addr[14:13], addr[11:7]};
  endfunction

  function automatic logic [IDX_W-1:0] low_idx(input logic [ADDR_W-1:0] addr);
    return addr[6:0];
  endfunction

endpackage

// File: rtl/pn_spike_rx_if.sv
// Packet-in / beat-out bus of the spike receiver; master is the environment
// side (packet source and beat sink), slave is the receiver.
interface pn_spike_rx_if;
  import pn_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_ADDR;
  logic [DATA_W-1:0] in_DATA;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_ADDR;
  logic [DATA_W-1:0] out_DATA;
  logic              out_spike;
  logic [IDX_W-1:0]  out_syn_idx;

  modport master (
    output in_valid, in_ADDR, in_DATA, out_ready,
    input  in_ready, out_valid, out_ADDR, out_DATA, out_spike, out_syn_idx
  );

  modport slave (
    input  in_valid, in_ADDR, in_DATA, out_ready,
    output in_ready, out_valid, out_ADDR, out_DATA, out_spike, out_syn_idx
  );
endinterface

// File: rtl/pn_pkt_fifo.sv
// Packet FIFO holding {ADDR, DATA}; power-of-two depth so pointers wrap naturally.
module pn_pkt_fifo
  import pn_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [PKT_W-1:0] din,
  input  logic             pop,
  output logic [PKT_W-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [PKT_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_s, pop_s, full_s, empty_s;

  assign full_s  = (count_r == CNT_W'(DEPTH));
  assign empty_s = (count_r == {CNT_W{1'b0}});
  assign push_s  = push & ~full_s;
  assign pop_s   = pop & ~empty_s;
  assign full    = full_s;
  assign empty   = empty_s;
  assign dout    = mem_r[rd_ptr_r];

  // pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // entry storage, contents are don't-care until pushed
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wr_ptr_r] <= din;
  end
endmodule

// File: rtl/pn_spike_rx.sv
// Spike receiver: buffers packets and splits them into decoder beats
// (DUAL spikes become two beats), counting delivered spike beats.
module pn_spike_rx
  import pn_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  pn_spike_rx_if.slave bus,
  output logic [15:0]  spike_cnt
);
  split_state_e      state_r, state_next_s;
  pkt_t              fifo_din_s, fifo_dout_s;
  pkt_class_e        load_cls_s;
  logic              fifo_full_s, fifo_empty_s;
  logic              fire_s, held_dual_s, load_s, second_s, load_spike_s;
  logic [IDX_W-1:0]  load_idx_s;
  logic              valid_r, spike_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] data_r;
  logic [IDX_W-1:0]  idx_r;
  logic [15:0]       spike_cnt_r;

  assign fifo_din_s.addr = bus.in_ADDR;
  assign fifo_din_s.data = bus.in_DATA;
  assign bus.in_ready    = ~fifo_full_s;

  pn_pkt_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.in_valid),
    .din   (fifo_din_s),
    .pop   (load_s),
    .dout  (fifo_dout_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  assign fire_s      = valid_r & bus.out_ready;
  assign held_dual_s = (pkt_class(addr_r) == PKT_DUAL);
  assign load_cls_s  = pkt_class(fifo_dout_s.addr);

  // split FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_next_s;
  end

  // split FSM next state
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (!fifo_empty_s) state_next_s = ST_FIRST;
        else               state_next_s = ST_IDLE;
      end
      ST_FIRST: begin
        if (fire_s && held_dual_s) state_next_s = ST_SECOND;
        else if (fire_s)           state_next_s = fifo_empty_s ? ST_IDLE : ST_FIRST;
        else                       state_next_s = ST_FIRST;
      end
      ST_SECOND: begin
        if (fire_s) state_next_s = fifo_empty_s ? ST_IDLE : ST_FIRST;
        else        state_next_s = ST_SECOND;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // split FSM outputs: pop a new packet or advance to the DUAL second beat
  always_comb begin
    load_s   = 1'b0;
    second_s = 1'b0;
    case (state_r)
      ST_IDLE:   load_s = ~fifo_empty_s;
      ST_FIRST: begin
        second_s = fire_s & held_dual_s;
        load_s   = fire_s & ~held_dual_s & ~fifo_empty_s;
      end
      ST_SECOND: load_s = fire_s & ~fifo_empty_s;
      default: begin
        load_s   = 1'b0;
        second_s = 1'b0;
      end
    endcase
  end

  // first-beat decode of the packet at the FIFO head
  always_comb begin
    load_spike_s = 1'b0;
    load_idx_s   = {IDX_W{1'b0}};
    case (load_cls_s)
      PKT_DUAL: begin
        load_spike_s = 1'b1;
        load_idx_s   = dual_idx0(fifo_dout_s.addr);
      end
      PKT_RICH: begin
        load_spike_s = 1'b1;
        load_idx_s   = low_idx(fifo_dout_s.addr);
      end
      default: begin
        load_spike_s = 1'b0;
        load_idx_s   = {IDX_W{1'b0}};
      end
    endcase
  end

  // output beat register; fields hold while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= 1'b0;
      addr_r  <= {ADDR_W{1'b0}};
      data_r  <= {DATA_W{1'b0}};
      spike_r <= 1'b0;
      idx_r   <= {IDX_W{1'b0}};
    end else if (load_s) begin
      valid_r <= 1'b1;
      addr_r  <= fifo_dout_s.addr;
      data_r  <= fifo_dout_s.data;
      spike_r <= load_spike_s;
      idx_r   <= load_idx_s;
    end else if (second_s) begin
      idx_r   <= low_idx(addr_r);
    end else if (fire_s) begin
      valid_r <= 1'b0;
    end
  end

  // saturating count of delivered spike beats
  always_ff @(posedge clk) begin
    if (rst) spike_cnt_r <= 16'd0;
    else if (fire_s && spike_r && (spike_cnt_r != CNT_MAX)) spike_cnt_r <= spike_cnt_r + 16'd1;
  end

  assign bus.out_valid   = valid_r;
  assign bus.out_ADDR    = addr_r;
  assign bus.out_DATA    = data_r;
  assign bus.out_spike   = spike_r;
  assign bus.out_syn_idx = idx_r;
  assign spike_cnt       = spike_cnt_r;
endmodule

// File: tb/tb_pn_spike_rx.sv
// Directed bench for pn_spike_rx: table of single-packet vectors plus
// backpressure, mid-DUAL reset and counter saturation sequences.
module tb_pn_spike_rx;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] spike_cnt;
  int          errors = 0;
  int          checks = 0;
  int          exp_cnt = 0;

  pn_spike_rx_if bus();

  pn_spike_rx #(.DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .spike_cnt (spike_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
    int          nbeats;
    logic        spike;
    logic [6:0]  idx0;
    logic [6:0]  idx1;
  } vec_t;

  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
    logic        spike;
    logic [6:0]  idx;
  } beat_t;

  vec_t  vec  [8];
  beat_t exp_b[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [15:0] a, input logic [31:0] d);
    bus.in_valid = 1'b1;
    bus.in_ADDR  = a;
    bus.in_DATA  = d;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  initial begin
    int got, first_cyc, last_cyc, cyc, vcount;
    bus.in_valid  = 1'b0;
    bus.in_ADDR   = 16'h0000;
    bus.in_DATA   = 32'h0;
    bus.out_ready = 1'b1;

    vec[0] = '{16'hA005, 32'h1234_5678, 1, 1'b0, 7'h00, 7'h00};
    vec[1] = '{16'h6C85, 32'hCAFE_0001, 2, 1'b1, 7'b1111001, 7'h05};
    vec[2] = '{16'h1023, 32'h0000_00A5, 1, 1'b1, 7'h23, 7'h00};
    vec[3] = '{16'hFFFF, 32'hDEAD_BEEF, 1, 1'b0, 7'h00, 7'h00};
    vec[4] = '{16'h0000, 32'h0000_0000, 2, 1'b1, 7'h00, 7'h00};
    vec[5] = '{16'h6F80, 32'h1111_2222, 2, 1'b1, 7'h7F, 7'h00};
    vec[6] = '{16'h107F, 32'h3333_4444, 1, 1'b1, 7'h7F, 7'h00};
    vec[7] = '{16'h2A55, 32'h5555_6666, 2, 1'b1, 7'h34, 7'h55};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_addr", bus.out_ADDR, 16'h0);
    chk("rst_out_data", bus.out_DATA, 32'h0);
    chk("rst_out_spike", bus.out_spike, 1'b0);
    chk("rst_out_idx", bus.out_syn_idx, 7'h0);
    chk("rst_spike_cnt", spike_cnt, 16'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_in_ready", bus.in_ready, 1'b1);

    // single-packet vectors, out_ready high
    for (int i = 0; i < 8; i++) begin
      chk("vec_in_ready", bus.in_ready, 1'b1);
      push(vec[i].addr, vec[i].data);
      chk("vec_no_bypass", bus.out_valid, 1'b0);
      @(posedge clk); #1;
      chk("vec_b0_valid", bus.out_valid, 1'b1);
      chk("vec_b0_addr", bus.out_ADDR, vec[i].addr);
      chk("vec_b0_data", bus.out_DATA, vec[i].data);
      chk("vec_b0_spike", bus.out_spike, vec[i].spike);
      chk("vec_b0_idx", bus.out_syn_idx, vec[i].idx0);
      @(posedge clk); #1;
      if (vec[i].nbeats == 2) begin
        chk("vec_b1_valid", bus.out_valid, 1'b1);
        chk("vec_b1_addr", bus.out_ADDR, vec[i].addr);
        chk("vec_b1_spike", bus.out_spike, 1'b1);
        chk("vec_b1_idx", bus.out_syn_idx, vec[i].idx1);
        @(posedge clk); #1;
      end
      if (vec[i].spike) exp_cnt += vec[i].nbeats;
      chk("vec_drained", bus.out_valid, 1'b0);
      chk("vec_spike_cnt", spike_cnt, exp_cnt);
    end

    // backpressure: fill output register plus FIFO, then drain
    exp_b[0] = '{16'h8001, 32'h0000_0100, 1'b0, 7'h00};
    exp_b[1] = '{16'h1011, 32'h0000_0101, 1'b1, 7'h11};
    exp_b[2] = '{16'h0203, 32'h0000_0102, 1'b1, 7'h04};
    exp_b[3] = '{16'h0203, 32'h0000_0102, 1'b1, 7'h03};
    exp_b[4] = '{16'h9004, 32'h0000_0103, 1'b0, 7'h00};
    exp_b[5] = '{16'h1045, 32'h0000_0104, 1'b1, 7'h45};
    bus.out_ready = 1'b0;
    push(16'h8001, 32'h0000_0100);
    push(16'h1011, 32'h0000_0101);
    push(16'h0203, 32'h0000_0102);
    push(16'h9004, 32'h0000_0103);
    chk("bp_ready_before_last", bus.in_ready, 1'b1);
    push(16'h1045, 32'h0000_0104);
    chk("bp_full", bus.in_ready, 1'b0);
    push(16'hBBBB, 32'hBAD0_BAD0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_hold_valid", bus.out_valid, 1'b1);
      chk("bp_hold_addr", bus.out_ADDR, 16'h8001);
      chk("bp_hold_data", bus.out_DATA, 32'h0000_0100);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    got = 0; first_cyc = -1; last_cyc = -1;
    for (cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        if (got < 6) begin
          chk("bp_addr", bus.out_ADDR, exp_b[got].addr);
          chk("bp_data", bus.out_DATA, exp_b[got].data);
          chk("bp_spike", bus.out_spike, exp_b[got].spike);
          chk("bp_idx", bus.out_syn_idx, exp_b[got].idx);
          if (exp_b[got].spike) exp_cnt++;
        end
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        got++;
      end
    end
    chk("bp_beat_count", got, 6);
    chk("bp_throughput", last_cyc - first_cyc, 5);
    chk("bp_spike_cnt", spike_cnt, exp_cnt);
    chk("bp_ready_again", bus.in_ready, 1'b1);

    // reset while in SECOND with two packets queued
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    push(16'h6C85, 32'h0000_0200);
    push(16'h1023, 32'h0000_0201);
    push(16'hA005, 32'h0000_0202);
    chk("mr_b0_idx", bus.out_syn_idx, 7'b1111001);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("mr_second_valid", bus.out_valid, 1'b1);
    chk("mr_second_idx", bus.out_syn_idx, 7'h05);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mr_out_valid", bus.out_valid, 1'b0);
    chk("mr_spike_cnt", spike_cnt, 16'h0);
    bus.out_ready = 1'b1;
    vcount = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.out_valid) vcount++;
    end
    chk("mr_no_beats", vcount, 0);
    chk("mr_in_ready", bus.in_ready, 1'b1);

    // counter saturation from a forced near-max value
    @(negedge clk);
    force dut.spike_cnt_r = 16'hFFFE;
    @(negedge clk);
    release dut.spike_cnt_r;
    @(posedge clk); #1;
    chk("sat_preload", spike_cnt, 16'hFFFE);
    push(16'h0000, 32'h0000_0300);
    @(posedge clk); #1;
    chk("sat_b0_valid", bus.out_valid, 1'b1);
    @(posedge clk); #1;
    chk("sat_after_b0", spike_cnt, 16'hFFFF);
    @(posedge clk); #1;
    chk("sat_after_b1", spike_cnt, 16'hFFFF);
    chk("sat_drained", bus.out_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
